// File: rtl/delay_buffer_flow_ctrl_if.sv
// Upstream (s_*) and downstream (m_*) beat streams of the delay-buffer flow controller.
// Handshake: a beat transfers on a posedge where valid && ready; valid never waits on ready.
interface delay_buffer_flow_ctrl_if #(
    parameter int N         = 4,
    parameter int PRECISION = 4
);
    logic                          s_valid;
    logic                          s_ready;
    logic [N-1:0][PRECISION-1:0]   s_data;
    logic                          m_valid;
    logic                          m_ready;
    logic [N-1:0][PRECISION-1:0]   m_data;

    // master: the flow controller itself; slave: the producer/consumer environment.
    modport master (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );
    modport slave (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );
endinterface

// File: rtl/delay_buffer_flow_ctrl.sv
// Credit-based valid/ready controller around a fixed-latency, non-stallable N-lane datapath:
// tracks a valid token per datapath stage and lands aligned outputs in a FWFT output FIFO.
module delay_buffer_flow_ctrl #(
    parameter int N          = 4,
    parameter int PRECISION  = 4,
    parameter int DP_LATENCY = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int CW = $clog2(DP_LATENCY + 1),
    localparam int FW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    delay_buffer_flow_ctrl_if.master    bus,
    output logic [N-1:0][PRECISION-1:0] dp_idata,
    input  logic [N-1:0][PRECISION-1:0] dp_odata,
    output logic [CW-1:0]               inflight_cnt,
    output logic [FW-1:0]               fifo_cnt,
    output logic                        ovf_err
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SW = ((FW > CW) ? FW : CW) + 1;
    localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

    typedef logic [N-1:0][PRECISION-1:0] beat_t;

    beat_t                  mem [FIFO_DEPTH];
    logic [DP_LATENCY-1:0]  vp;
    logic [DP_LATENCY-1:0]  vp_next;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [SW-1:0]          used;
    logic                   s_ready_int;
    logic                   m_valid_int;
    logic                   fire;
    logic                   capture;
    logic                   pop;
    logic                   full;
    logic                   wr_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Every beat in flight already owns a FIFO slot, so a capture always finds room.
    always_comb begin
        used        = SW'(fifo_cnt) + SW'(inflight_cnt);
        s_ready_int = rst_n && !flush && (used < SW'(FIFO_DEPTH));
        fire        = bus.s_valid && s_ready_int;
        capture     = vp[DP_LATENCY-1];
        full        = (fifo_cnt == FW'(FIFO_DEPTH));
        m_valid_int = rst_n && (fifo_cnt != '0);
        pop         = m_valid_int && bus.m_ready;
        wr_en       = capture && (!full || pop);
        dp_idata    = fire ? bus.s_data : '0;
    end

    always_comb begin
        vp_next    = '0;
        vp_next[0] = fire;
        for (int i = 1; i < DP_LATENCY; i++) begin
            vp_next[i] = vp[i-1];
        end
    end

    assign bus.s_ready = s_ready_int;
    assign bus.m_valid = m_valid_int;
    assign bus.m_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vp           <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            inflight_cnt <= '0;
            ovf_err      <= 1'b0;
        end else if (flush) begin
            // Datapath keeps running on stale data; clearing vp leaves it unmarked.
            vp           <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            inflight_cnt <= '0;
        end else begin
            vp           <= vp_next;
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)   rd_ptr <= ptr_inc(rd_ptr);
            fifo_cnt     <= fifo_cnt + FW'(wr_en) - FW'(pop);
            inflight_cnt <= inflight_cnt + CW'(fire) - CW'(capture);
            if (capture && full && !pop) ovf_err <= 1'b1;
        end
    end

    // Storage has no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && wr_en) mem[wr_ptr] <= dp_odata;
    end
endmodule
